// File: rtl/mdu_iter_if.sv
// Request/response bundle between the controller's MDop path and mdu_iter.
// MDU_HILO_WR_EN adds the MTHI/MTLO write signals.
interface mdu_iter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             ready;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             divz;
`ifdef MDU_HILO_WR_EN
    logic [1:0]       hilo_we;
    logic [WIDTH-1:0] hilo_wd;
`endif

    modport master (
`ifdef MDU_HILO_WR_EN
        output hilo_we, hilo_wd,
`endif
        output start, op, a, b,
        input  busy, ready, hi, lo, divz
    );

    modport slave (
`ifdef MDU_HILO_WR_EN
        input  hilo_we, hilo_wd,
`endif
        input  start, op, a, b,
        output busy, ready, hi, lo, divz
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, WIDTH iterations.
// Optional MTHI/MTLO write port enabled by macro MDU_HILO_WR_EN.
module mdu_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic        clk,
    input logic        reset,
    mdu_iter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t               state;
    logic [1:0]           op_q;
    logic                 neg_res;
    logic                 neg_dvd;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opnd;
    logic                 busy_q;
    logic                 ready_q;
    logic                 divz_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    logic [WIDTH-1:0]     a_abs_c;
    logic [WIDTH-1:0]     b_abs_c;
    logic [WIDTH:0]       mul_sum_c;
    logic [2*WIDTH-1:0]   mul_next_c;
    logic [WIDTH:0]       dvd_top_c;
    logic                 dvd_fits_c;
    logic [WIDTH-1:0]     rem_sub_c;
    logic [2*WIDTH-1:0]   div_next_c;
    logic [2*WIDTH-1:0]   prod_fix_c;
    logic [WIDTH-1:0]     quo_fix_c;
    logic [WIDTH-1:0]     rem_fix_c;

    // Operand magnitudes, one iteration step for each op, and final sign fix-up
    always_comb begin
        a_abs_c    = (bus.op[0] && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_abs_c    = (bus.op[0] && bus.b[WIDTH-1]) ? -bus.b : bus.b;

        mul_sum_c  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        mul_next_c = acc[0] ? {mul_sum_c, acc[WIDTH-1:1]}
                            : {1'b0, acc[2*WIDTH-1:1]};

        // Top WIDTH+1 bits hold the partial remainder already shifted left by one
        dvd_top_c  = acc[2*WIDTH-1:WIDTH-1];
        dvd_fits_c = dvd_top_c >= {1'b0, opnd};
        rem_sub_c  = dvd_top_c[WIDTH-1:0] - opnd;
        div_next_c = dvd_fits_c ? {rem_sub_c, acc[WIDTH-2:0], 1'b1}
                                : {acc[2*WIDTH-2:0], 1'b0};

        prod_fix_c = neg_res ? -acc : acc;
        quo_fix_c  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix_c  = neg_dvd ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= 2'b00;
            neg_res <= 1'b0;
            neg_dvd <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            divz_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            ready_q <= 1'b0;
`ifdef MDU_HILO_WR_EN
            if (!busy_q) begin
                if (bus.hilo_we[1]) hi_q <= bus.hilo_wd;
                if (bus.hilo_we[0]) lo_q <= bus.hilo_wd;
            end
`endif
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        op_q    <= bus.op;
                        neg_res <= bus.op[0] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_dvd <= bus.op[0] & bus.a[WIDTH-1];
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                        if (bus.op[1] && (bus.b == '0)) begin
                            // Divide by zero skips the iterations; keep raw a for hi
                            divz_q <= 1'b1;
                            acc    <= {bus.a, {WIDTH{1'b0}}};
                            state  <= FIX;
                        end else begin
                            divz_q <= 1'b0;
                            opnd   <= bus.op[1] ? b_abs_c : a_abs_c;
                            acc    <= {{WIDTH{1'b0}}, bus.op[1] ? a_abs_c : b_abs_c};
                            state  <= CALC;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    acc <= op_q[1] ? div_next_c : mul_next_c;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    if (divz_q) begin
                        hi_q <= acc[2*WIDTH-1:WIDTH];
                        lo_q <= {WIDTH{1'b1}};
                    end else if (op_q[1]) begin
                        hi_q <= rem_fix_c;
                        lo_q <= quo_fix_c;
                    end else begin
                        hi_q <= prod_fix_c[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix_c[WIDTH-1:0];
                    end
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.ready = ready_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.divz  = divz_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Directed-vector bench for mdu_iter: table of ops plus busy-start, back-to-back and reset sequences.
module tb_mdu_iter;
    localparam int unsigned WIDTH = 32;
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;
    localparam int NV = 14;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        divz;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[NV];

    always #5 clk = ~clk;

    mdu_iter_if #(.WIDTH(WIDTH)) bus ();

    mdu_iter #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Pulse start for one edge; scramble operands afterwards to prove they are latched
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.op    = 2'($urandom);
    endtask

    // Count edges until ready (bounded) and busy-high samples along the way
    task automatic wait_ready(output int lat, output int bcnt);
        lat  = 0;
        bcnt = (bus.busy === 1'b1) ? 1 : 0;
        while (bus.ready !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy === 1'b1) bcnt++;
        end
    endtask

    initial begin
        int lat;
        int bcnt;

        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
`ifdef MDU_HILO_WR_EN
        bus.hilo_we = 2'b00;
        bus.hilo_wd = '0;
`endif
        reset = 1'b1;

        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 33};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vecs[3]  = '{OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1, 1};
        vecs[4]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33};
        vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
        vecs[6]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
        vecs[7]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
        vecs[8]  = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0, 33};
        vecs[9]  = '{OP_DIV,   32'd0,        32'd0,        32'h00000000, 32'hFFFFFFFF, 1'b1, 1};
        vecs[10] = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 33};
        vecs[11] = '{OP_DIVU,  32'd5,        32'd7,        32'd5,        32'd0,        1'b0, 33};
        vecs[12] = '{OP_DIV,   32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0, 33};
        vecs[13] = '{OP_DIVU,  32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'h00000001, 1'b0, 33};

        repeat (2) @(posedge clk);
        #1;
        check("reset busy",  64'(bus.busy),  64'(0));
        check("reset ready", 64'(bus.ready), 64'(0));
        check("reset hi",    64'(bus.hi),    64'(0));
        check("reset lo",    64'(bus.lo),    64'(0));
        check("reset divz",  64'(bus.divz),  64'(0));
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_ready(lat, bcnt);
            check($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d busy_cycles", i), 64'(bcnt), 64'(vecs[i].lat));
            check($sformatf("v%0d hi", i), 64'(bus.hi), 64'(vecs[i].hi));
            check($sformatf("v%0d lo", i), 64'(bus.lo), 64'(vecs[i].lo));
            check($sformatf("v%0d divz", i), 64'(bus.divz), 64'(vecs[i].divz));
            @(posedge clk);
            #1;
            check($sformatf("v%0d ready_pulse", i), 64'(bus.ready), 64'(0));
            check($sformatf("v%0d hold_lo", i), 64'(bus.lo), 64'(vecs[i].lo));
        end

        // start while busy is ignored; result and timing follow the first request
        start_op(OP_MULTU, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.a     = 32'd99;
        bus.b     = 32'd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("ign busy", 64'(bus.busy), 64'(1));
        wait_ready(lat, bcnt);
        check("ign latency", 64'(lat), 64'(23));
        check("ign hi", 64'(bus.hi), 64'(0));
        check("ign lo", 64'(bus.lo), 64'(15));

        // Back-to-back start in the DONE cycle
        start_op(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("b2b ready_drop", 64'(bus.ready), 64'(0));
        check("b2b busy_rise",  64'(bus.busy),  64'(1));
        wait_ready(lat, bcnt);
        check("b2b latency", 64'(lat), 64'(33));
        check("b2b hi", 64'(bus.hi), 64'(0));
        check("b2b lo", 64'(bus.lo), 64'(1));

        // Reset in the middle of a divide
        start_op(OP_DIVU, 32'd1000, 32'd3);
        repeat (15) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst busy",  64'(bus.busy),  64'(0));
        check("midrst ready", 64'(bus.ready), 64'(0));
        check("midrst hi",    64'(bus.hi),    64'(0));
        check("midrst lo",    64'(bus.lo),    64'(0));
        @(negedge clk);
        reset = 1'b0;
        start_op(OP_MULTU, 32'd2, 32'd3);
        wait_ready(lat, bcnt);
        check("postrst latency", 64'(lat), 64'(33));
        check("postrst hi", 64'(bus.hi), 64'(0));
        check("postrst lo", 64'(bus.lo), 64'(6));

`ifdef MDU_HILO_WR_EN
        @(negedge clk);
        bus.hilo_we = 2'b10;
        bus.hilo_wd = 32'h00001234;
        @(posedge clk);
        #1;
        bus.hilo_we = 2'b00;
        check("mthi hi", 64'(bus.hi), 64'(32'h00001234));
        check("mthi lo", 64'(bus.lo), 64'(6));
        start_op(OP_MULTU, 32'd1, 32'd1);
        @(negedge clk);
        bus.hilo_we = 2'b11;
        bus.hilo_wd = 32'h0000DEAD;
        @(posedge clk);
        #1;
        bus.hilo_we = 2'b00;
        check("busywr hi", 64'(bus.hi), 64'(32'h00001234));
        check("busywr lo", 64'(bus.lo), 64'(6));
        wait_ready(lat, bcnt);
        check("busywr final lo", 64'(bus.lo), 64'(1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
